// File: rtl/wbc_pwr_seq.sv
// Processor-side DCLO/ACLO power sequencer: core reset, bus INIT, power-up and power-fail requests.
// Optional ACLO glitch filter is built when PWR_ACLO_FILTER_EN is defined.
module wbc_pwr_seq #(
  parameter int INIT_WIDTH  = 16,
  parameter int PU_DELAY    = 4,
  parameter int ACLO_FILTER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_us,
  input  logic       dclo,
  input  logic       aclo,
  input  logic       vec_ack,
  output logic       cpu_rst,
  output logic       bus_init,
  output logic       pu_req,
  output logic       pf_req,
  output logic [2:0] state
);

  // state  | meaning
  // OFF    | DCLO asserted, core held in reset
  // INIT   | bus INIT pulse in progress
  // ACWAIT | waiting for ACLO clear for PU_DELAY strobes
  // PWRUP  | power-up restart requested, waiting for ack
  // RUN    | normal operation
  // PFAIL  | power-fail trap requested, waiting for ack
  // PFWAIT | power-fail handler running, waiting for ACLO clear or DCLO
  typedef enum logic [2:0] {
    OFF    = 3'd0,
    INIT   = 3'd1,
    ACWAIT = 3'd2,
    PWRUP  = 3'd3,
    RUN    = 3'd4,
    PFAIL  = 3'd5,
    PFWAIT = 3'd6
  } state_t;

  localparam int IW = $clog2(INIT_WIDTH + 1);
  localparam int DW = (PU_DELAY > 0) ? $clog2(PU_DELAY + 1) : 1;
  localparam logic [IW-1:0] INIT_TC = IW'(INIT_WIDTH - 1);
  localparam logic [DW-1:0] DLY_TC  = DW'(PU_DELAY);

  if (INIT_WIDTH < 1 || ACLO_FILTER < 1) begin : g_param_chk
    $error("wbc_pwr_seq: INIT_WIDTH and ACLO_FILTER must be >= 1");
  end

  state_t        st, st_nx;
  logic [IW-1:0] init_cnt, init_nx;
  logic [DW-1:0] dly_cnt, dly_nx, dly_inc;
  logic          dclo_m, dclo_s, aclo_m, aclo_s;
  logic          aclo_f;

  // Synchronizers come out of reset treating power as low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclo_m <= 1'b1;
      dclo_s <= 1'b1;
      aclo_m <= 1'b1;
      aclo_s <= 1'b1;
    end else begin
      dclo_m <= dclo;
      dclo_s <= dclo_m;
      aclo_m <= aclo;
      aclo_s <= aclo_m;
    end
  end

`ifdef PWR_ACLO_FILTER_EN
  localparam int FW = (ACLO_FILTER > 1) ? $clog2(ACLO_FILTER) : 1;
  localparam logic [FW-1:0] FLT_TC = FW'(ACLO_FILTER - 1);
  logic [FW-1:0] flt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      aclo_f  <= 1'b1;
    end else if (aclo_s == aclo_f) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_TC) begin
      flt_cnt <= '0;
      aclo_f  <= aclo_s;
    end else begin
      flt_cnt <= flt_cnt + FW'(1);
    end
  end
`else
  assign aclo_f = aclo_s;
`endif

  always_comb begin
    st_nx   = st;
    init_nx = init_cnt;
    dly_nx  = dly_cnt;
    dly_inc = (ena_us && dly_cnt != DLY_TC) ? dly_cnt + DW'(1) : dly_cnt;
    case (st)
      OFF: begin
        init_nx = '0;
        dly_nx  = '0;
        if (!dclo_s) st_nx = INIT;
      end
      INIT: begin
        if (init_cnt == INIT_TC) begin
          st_nx   = ACWAIT;
          init_nx = '0;
        end else begin
          init_nx = init_cnt + IW'(1);
        end
      end
      ACWAIT: begin
        if (aclo_f) begin
          dly_nx = '0;
        end else if (dly_inc == DLY_TC) begin
          st_nx  = PWRUP;
          dly_nx = '0;
        end else begin
          dly_nx = dly_inc;
        end
      end
      PWRUP:  if (vec_ack) st_nx = RUN;
      RUN:    if (aclo_f) st_nx = PFAIL;
      PFAIL:  if (vec_ack) st_nx = PFWAIT;
      PFWAIT: begin
        if (!aclo_f) begin
          st_nx   = INIT;
          init_nx = '0;
        end
      end
      default: st_nx = OFF;
    endcase
    // DCLO overrides everything, including a same-cycle ack.
    if (dclo_s) begin
      st_nx   = OFF;
      init_nx = '0;
      dly_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= OFF;
      init_cnt <= '0;
      dly_cnt  <= '0;
      cpu_rst  <= 1'b1;
      bus_init <= 1'b0;
      pu_req   <= 1'b0;
      pf_req   <= 1'b0;
    end else begin
      st       <= st_nx;
      init_cnt <= init_nx;
      dly_cnt  <= dly_nx;
      cpu_rst  <= (st_nx == OFF) || (st_nx == INIT) || (st_nx == ACWAIT);
      bus_init <= (st_nx == INIT);
      pu_req   <= (st_nx == PWRUP);
      pf_req   <= (st_nx == PFAIL);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_wbc_pwr_seq.sv
// Directed, partly randomized bench for wbc_pwr_seq with expectations derived from protocol timing.
module tb_wbc_pwr_seq;

  localparam int PU = 4;
  localparam int IW = 16;
`ifdef PWR_ACLO_FILTER_EN
  localparam int FLT = 4;
`else
  localparam int FLT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena_us, dclo, aclo, vec_ack;
  logic       cpu_rst, bus_init, pu_req, pf_req;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  wbc_pwr_seq #(.INIT_WIDTH(IW), .PU_DELAY(PU), .ACLO_FILTER(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena_us(ena_us), .dclo(dclo), .aclo(aclo),
    .vec_ack(vec_ack), .cpu_rst(cpu_rst), .bus_init(bus_init),
    .pu_req(pu_req), .pf_req(pf_req), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count cycles with bus_init high, starting on the first cycle it is seen high.
  task automatic measure_init(input string tag);
    int n = 0;
    for (int k = 0; k < 100 && bus_init === 1'b1; k++) begin
      n++;
      cyc(1);
    end
    chk({tag, "_width"}, n, IW);
    chk({tag, "_acwait"}, state, 2);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
  endtask

  // ACLO already clear: PWRUP is reached on the edge that takes the PU-th strobe.
  task automatic strobe_to_pwrup(input string tag);
    int seen = 0;
    for (int i = 0; i < PU; i++) begin
      int gap = $urandom_range(0, 5);
      if (gap > 0) cyc(gap);
      ena_us = 1'b1;
      cyc(1);
      ena_us = 1'b0;
      seen++;
      chk({tag, "_pu_req"}, pu_req, (seen >= PU) ? 1 : 0);
      chk({tag, "_state"}, state, (seen >= PU) ? 3 : 2);
      chk({tag, "_cpu_rst"}, cpu_rst, (seen >= PU) ? 0 : 1);
    end
  endtask

  task automatic ack;
    vec_ack = 1'b1;
    cyc(1);
    vec_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena_us = 1'b0; dclo = 1'b1; aclo = 1'b1; vec_ack = 1'b0;
    cyc(3);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_bus_init", bus_init, 0);
    chk("rst_pu_req", pu_req, 0);
    chk("rst_pf_req", pf_req, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    cyc(4);
    chk("off_hold", state, 0);

    // Power-up: DCLO clears, INIT after sync latency plus one.
    dclo = 1'b0;
    cyc(2);
    chk("sync_lat_off", state, 0);
    cyc(1);
    chk("init_entry", state, 1);
    chk("init_bus_init", bus_init, 1);
    chk("init_cpu_rst", cpu_rst, 1);
    measure_init("init1");

    // Strobes with ACLO still high do not advance.
    repeat (6) begin
      ena_us = 1'b1;
      cyc(1);
      ena_us = 1'b0;
      cyc($urandom_range(1, 3));
    end
    chk("acwait_aclo_hi", state, 2);
    chk("acwait_no_pu", pu_req, 0);

    aclo = 1'b0;
    cyc(3 + FLT);
    chk("acwait_settle", state, 2);
    strobe_to_pwrup("pu1");
    ack();
    chk("run_state", state, 4);
    chk("run_pu_req", pu_req, 0);
    chk("run_cpu_rst", cpu_rst, 0);
    ack();
    cyc(2);
    chk("run_ack_ignored", state, 4);

    // Power fail in RUN; ACLO clearing before ack keeps the request.
    aclo = 1'b1;
    cyc(2 + FLT);
    chk("pf_not_yet", pf_req, 0);
    cyc(1);
    chk("pf_req", pf_req, 1);
    chk("pf_state", state, 5);
    aclo = 1'b0;
    cyc(4 + FLT);
    chk("pf_held", pf_req, 1);
    chk("pf_held_state", state, 5);
    ack();
    chk("pfwait_state", state, 6);
    chk("pfwait_pf_req", pf_req, 0);
    chk("pfwait_cpu_rst", cpu_rst, 0);
    cyc(1);
    chk("recover_init", state, 1);
    chk("recover_cpu_rst", cpu_rst, 1);
    measure_init("init2");
    strobe_to_pwrup("pu2");

    // ACLO rises in PWRUP with ack on the same cycle: RUN for one cycle, then PFAIL.
    aclo = 1'b1;
    cyc(2 + FLT);
    chk("pwrup_no_abort", state, 3);
    chk("pwrup_pu_held", pu_req, 1);
    ack();
    chk("race_run", state, 4);
    chk("race_pu_req", pu_req, 0);
    cyc(1);
    chk("race_pfail", state, 5);
    chk("race_pf_req", pf_req, 1);

    // DCLO in PFAIL with a same-cycle ack: OFF wins.
    dclo = 1'b1;
    cyc(2);
    chk("dclo_pre", state, 5);
    ack();
    chk("dclo_off", state, 0);
    chk("dclo_cpu_rst", cpu_rst, 1);
    chk("dclo_pf_req", pf_req, 0);
    chk("dclo_bus_init", bus_init, 0);
    chk("dclo_pu_req", pu_req, 0);

    // Restart, then ACLO glitch handling in RUN.
    dclo = 1'b0;
    aclo = 1'b0;
    cyc(3);
    chk("restart_init", state, 1);
    measure_init("init3");
    strobe_to_pwrup("pu3");
    ack();
    chk("run2_state", state, 4);
    aclo = 1'b1;
    cyc(3);
    aclo = 1'b0;
    cyc(6);
    chk("glitch_pf_req", pf_req, (FLT > 0) ? 0 : 1);
    chk("glitch_state", state, (FLT > 0) ? 4 : 5);
    aclo = 1'b1;
    cyc(3 + FLT);
    chk("stable_pf_req", pf_req, 1);
    chk("stable_state", state, 5);

    // PFWAIT with ACLO still high, then DCLO forces OFF.
    ack();
    cyc(2);
    chk("pfwait2_state", state, 6);
    chk("pfwait2_cpu_rst", cpu_rst, 0);
    dclo = 1'b1;
    cyc(3);
    chk("pfwait_dclo_off", state, 0);
    chk("pfwait_dclo_rst", cpu_rst, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
